// File: rtl/intersection_controller.sv
// intersection_controller: two-road light sequencer with latched side-road and pedestrian requests.
// Define PED_WALK_EN to include the pedestrian walk phase.
module intersection_controller #(
  parameter int GREEN_CYCLES   = 8,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int PED_CYCLES     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_ew,
  input  logic       ped_req,
  output logic [1:0] ns_state,
  output logic [1:0] ew_state,
  output logic       walk,
  output logic       ped_ack
);
  localparam int M1 = GREEN_CYCLES > YELLOW_CYCLES ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int M2 = ALL_RED_CYCLES > PED_CYCLES ? ALL_RED_CYCLES : PED_CYCLES;
  localparam int TW = $clog2(M1 > M2 ? M1 : M2) + 1;
  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2
`ifdef PED_WALK_EN
    , PED_WALK
`endif
  } state_t;
  state_t state_q, state_d, ar1_next, ar2_next;
  logic [TW-1:0] timer, tload;
  logic ew_pend, ped_pend, expired, entry;
  assign expired = timer == '0;
  assign entry = state_d != state_q;
`ifdef PED_WALK_EN
  assign ar1_next = ew_pend ? EW_GREEN : PED_WALK;
  assign ar2_next = ped_pend ? PED_WALK : NS_GREEN;
  assign walk = state_q == PED_WALK;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ped_pend <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      ped_pend <= (entry && state_d == PED_WALK) ? 1'b0 : ped_pend | (ped_req && state_q != PED_WALK);
      ped_ack <= entry && state_d == PED_WALK;
    end
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ar1_next = EW_GREEN;
  assign ar2_next = NS_GREEN;
  assign ped_pend = 1'b0;
  assign walk = 1'b0;
  assign ped_ack = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  state_d = (expired && (ew_pend || ped_pend)) ? NS_YELLOW : NS_GREEN;
      NS_YELLOW: state_d = expired ? ALL_RED_1 : NS_YELLOW;
      ALL_RED_1: state_d = expired ? ar1_next : ALL_RED_1;
      EW_GREEN:  state_d = expired ? EW_YELLOW : EW_GREEN;
      EW_YELLOW: state_d = expired ? ALL_RED_2 : EW_YELLOW;
      ALL_RED_2: state_d = expired ? ar2_next : ALL_RED_2;
`ifdef PED_WALK_EN
      PED_WALK:  state_d = expired ? NS_GREEN : PED_WALK;
`endif
      default:   state_d = NS_GREEN;
    endcase
    tload = TW'(GREEN_CYCLES - 1);
    case (state_d)
      NS_YELLOW, EW_YELLOW: tload = TW'(YELLOW_CYCLES - 1);
      ALL_RED_1, ALL_RED_2: tload = TW'(ALL_RED_CYCLES - 1);
`ifdef PED_WALK_EN
      PED_WALK:             tload = TW'(PED_CYCLES - 1);
`endif
      default: ;
    endcase
  end
  // NS_GREEN rest: timer saturates at zero until a request is pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= NS_GREEN;
      timer <= TW'(GREEN_CYCLES - 1);
      ew_pend <= 1'b0;
    end else begin
      state_q <= state_d;
      timer <= entry ? tload : expired ? timer : timer - 1'b1;
      ew_pend <= (entry && state_d == EW_GREEN) ? 1'b0 : ew_pend | (sensor_ew && state_q != EW_GREEN);
    end
  assign ns_state = state_q == NS_GREEN ? 2'b01 : state_q == NS_YELLOW ? 2'b10 : 2'b00;
  assign ew_state = state_q == EW_GREEN ? 2'b01 : state_q == EW_YELLOW ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_intersection_controller.sv
// tb_intersection_controller: directed cycle-indexed checks of the light sequence, reset and request latching.
module tb_intersection_controller;
  localparam logic [1:0] R = 2'b00, G = 2'b01, Y = 2'b10;
  typedef struct {
    int cyc;
    logic s, p;
    logic [1:0] ns, ew;
    logic w, a;
  } vec_t;
  logic clk, rst_n, sensor_ew, ped_req, walk, ped_ack;
  logic [1:0] ns_state, ew_state;
  int checks = 0, failures = 0;
  vec_t v[$];
  intersection_controller dut (
    .clk(clk), .rst_n(rst_n), .sensor_ew(sensor_ew), .ped_req(ped_req),
    .ns_state(ns_state), .ew_state(ew_state), .walk(walk), .ped_ack(ped_ack)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int n, input logic [1:0] ens, input logic [1:0] eew, input logic ew, input logic ea);
    checks++;
    if (ns_state !== ens || ew_state !== eew || walk !== ew || ped_ack !== ea) begin
      failures++;
      $display("FAIL %s cyc=%0d got ns=%0d ew=%0d walk=%0d ack=%0d want ns=%0d ew=%0d walk=%0d ack=%0d",
               nm, n, ns_state, ew_state, walk, ped_ack, ens, eew, ew, ea);
    end
  endtask
  task automatic add(input int c, input logic s, input logic p, input logic [1:0] n, input logic [1:0] e, input logic w, input logic a);
    vec_t r;
    r.cyc = c; r.s = s; r.p = p; r.ns = n; r.ew = e; r.w = w; r.a = a;
    v.push_back(r);
  endtask
  // leaves the bench at a negedge with the next posedge being cycle 0's edge
  task automatic do_reset();
    rst_n = 1'b0; sensor_ew = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic run(input string nm);
    int k = 0;
    int last = v[v.size()-1].cyc;
    do_reset();
    for (int n = 0; n <= last; n++) begin
      sensor_ew = 1'b0; ped_req = 1'b0;
      if (k < v.size() && v[k].cyc == n) begin
        sensor_ew = v[k].s; ped_req = v[k].p;
        chk(nm, n, v[k].ns, v[k].ew, v[k].w, v[k].a);
        k++;
      end
      @(negedge clk);
    end
    sensor_ew = 1'b0; ped_req = 1'b0;
    v.delete();
  endtask
  initial begin
    do_reset();
    chk("reset", 0, G, R, 0, 0);
    for (int n = 0; n < 60; n++) begin
      chk("idle", n, G, R, 0, 0);
      @(negedge clk);
    end
    add(0,0,0,G,R,0,0); add(2,1,0,G,R,0,0); add(7,0,0,G,R,0,0); add(8,0,0,Y,R,0,0);
    add(10,0,0,Y,R,0,0); add(11,0,0,R,R,0,0); add(12,0,0,R,R,0,0); add(13,0,0,R,G,0,0);
    add(20,0,0,R,G,0,0); add(21,0,0,R,Y,0,0); add(23,0,0,R,Y,0,0); add(24,0,0,R,R,0,0);
    add(25,0,0,R,R,0,0); add(26,0,0,G,R,0,0); add(40,0,0,G,R,0,0);
    run("ew");
`ifdef PED_WALK_EN
    add(0,0,0,G,R,0,0); add(2,0,1,G,R,0,0); add(7,0,0,G,R,0,0); add(8,0,0,Y,R,0,0);
    add(10,0,0,Y,R,0,0); add(11,0,0,R,R,0,0); add(12,0,0,R,R,0,0); add(13,0,0,R,R,1,1);
    add(14,0,0,R,R,1,0); add(17,0,0,R,R,1,0); add(18,0,0,G,R,0,0); add(30,0,0,G,R,0,0);
    run("ped");
    add(2,1,1,G,R,0,0); add(8,0,0,Y,R,0,0); add(12,0,0,R,R,0,0); add(13,0,0,R,G,0,0);
    add(20,0,0,R,G,0,0); add(21,0,0,R,Y,0,0); add(25,0,0,R,R,0,0); add(26,0,0,R,R,1,1);
    add(27,0,1,R,R,1,0); add(30,0,0,R,R,1,0); add(31,0,0,G,R,0,0); add(45,0,0,G,R,0,0);
    run("both");
`endif
    do_reset();
    for (int n = 0; n < 15; n++) begin
      sensor_ew = n == 2;
      if (n == 13) chk("rst_pre", n, R, G, 0, 0);
      @(negedge clk);
    end
    sensor_ew = 1'b0;
    chk("rst_pre", 15, R, G, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 15, G, R, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      if (n == 0 || n == 7 || n == 8 || n == 12 || n == 20) chk("rst_restart", n, G, R, 0, 0);
      @(negedge clk);
    end
`ifndef PED_WALK_EN
    do_reset();
    ped_req = 1'b1;
    for (int n = 0; n < 60; n++) begin
      chk("noped", n, G, R, 0, 0);
      @(negedge clk);
    end
    ped_req = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
